// File: rtl/stream_box_filter.sv
`default_nettype none
// ============================================================================
// Module      : stream_box_filter
// Description : Streaming 1-D box (moving-sum) filter. One pixel per accepted
//               beat; the window covers the current pixel plus the TAPS-1
//               most recent pixels of the same row. Row starts either
//               zero-fill or replicate the first pixel into the history.
//               The sum is kept at full precision. A shifted, saturated copy
//               is produced as the normalised pixel.
// Ports       : clk_i        rising-edge clock
//               rst_ni       asynchronous active-low reset
//               in_valid_i   input beat valid
//               in_ready_o   block accepts a beat this cycle
//               in_data_i    unsigned pixel
//               in_sol_i     start of line (first pixel of a row)
//               out_valid_o  output beat valid
//               out_ready_i  sink accepts the output beat
//               out_sum_o    unsigned window sum (SUM_W bits)
//               out_data_o   min(out_sum >> SHIFT, 2^DATA_W-1)
//               out_sol_o    in_sol of the pixel that produced this beat
// Revision    : 1.0  initial release
// ============================================================================
module stream_box_filter #(
    parameter int DATA_W    = 8,
    parameter int TAPS      = 3,
    parameter int SUM_W     = DATA_W + $clog2(TAPS),
    parameter int SHIFT     = 0,
    parameter int EDGE_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sol_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SUM_W-1:0]  out_sum_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sol_o
);

    generate
        if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
            $error("stream_box_filter: TAPS must be in 2..16");
        end
    endgenerate

    localparam logic [SUM_W-1:0] c_sat_max = SUM_W'({DATA_W{1'b1}});

    // Output register and history state.
    logic              out_valid_q;
    logic [SUM_W-1:0]  out_sum_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sol_q;
    logic [DATA_W-1:0] hist_q [TAPS-1];   // hist_q[0] is the newest sample

    // Combinational datapath.
    logic              w_en;
    logic              w_accept;
    logic [DATA_W-1:0] w_hist_eff [TAPS-1];
    logic [SUM_W-1:0]  sum_d;
    logic [SUM_W-1:0]  w_shifted;
    logic [DATA_W-1:0] data_d;

    // The output register may advance when it is empty or being drained.
    // in_ready depends only on output-side state, never on in_valid.
    assign w_en       = !out_valid_q || out_ready_i;
    assign w_accept   = in_valid_i && w_en;
    assign in_ready_o = w_en;

    always_comb begin
        // On a row start the history is replaced before it is summed, so the
        // previous row never contributes to the first pixels of a new row.
        for (int k = 0; k < TAPS - 1; k++) begin
            w_hist_eff[k] = hist_q[k];
        end
        if (in_sol_i) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                w_hist_eff[k] = (EDGE_MODE == 1) ? in_data_i : '0;
            end
        end

        sum_d = SUM_W'(in_data_i);
        for (int k = 0; k < TAPS - 1; k++) begin
            sum_d = sum_d + SUM_W'(w_hist_eff[k]);
        end

        // Logical shift, then clamp to the pixel range.
        w_shifted = sum_d >> SHIFT;
        data_d    = (w_shifted > c_sat_max) ? {DATA_W{1'b1}}
                                            : w_shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_data_q  <= '0;
            out_sol_q   <= 1'b0;
            for (int k = 0; k < TAPS - 1; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            // When enabled, valid simply follows the input handshake: a beat
            // loads the register, no beat empties it.
            if (w_en) begin
                out_valid_q <= in_valid_i;
            end
            if (w_accept) begin
                out_sum_q  <= sum_d;
                out_data_q <= data_d;
                out_sol_q  <= in_sol_i;
                hist_q[0]  <= in_data_i;
                // Shift from the effective history so a row start leaves the
                // filled values behind it.
                for (int k = 1; k < TAPS - 1; k++) begin
                    hist_q[k] <= w_hist_eff[k-1];
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_data_o  = out_data_q;
    assign out_sol_o   = out_sol_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_box_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_box_filter
// Description : Directed bench for stream_box_filter. Three instances share
//               the input stream: zero edge / no shift, replicate edge /
//               no shift, and zero edge / shift by 2. Expected values are
//               hand-computed constants.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stream_box_filter;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_ni;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_sol_i;
    logic       out_ready_i;

    logic       e0_ready, e0_valid, e0_sol;
    logic [9:0] e0_sum;
    logic [7:0] e0_data;
    logic       e1_ready, e1_valid, e1_sol;
    logic [9:0] e1_sum;
    logic [7:0] e1_data;
    logic       s2_ready, s2_valid, s2_sol;
    logic [9:0] s2_sum;
    logic [7:0] s2_data;

    int n_checks = 0;
    int n_pass   = 0;

    stream_box_filter #(.DATA_W(8), .TAPS(3), .SHIFT(0), .EDGE_MODE(0)) u_e0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(e0_ready),
        .in_data_i(in_data_i), .in_sol_i(in_sol_i),
        .out_valid_o(e0_valid), .out_ready_i(out_ready_i),
        .out_sum_o(e0_sum), .out_data_o(e0_data), .out_sol_o(e0_sol)
    );

    stream_box_filter #(.DATA_W(8), .TAPS(3), .SHIFT(0), .EDGE_MODE(1)) u_e1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(e1_ready),
        .in_data_i(in_data_i), .in_sol_i(in_sol_i),
        .out_valid_o(e1_valid), .out_ready_i(out_ready_i),
        .out_sum_o(e1_sum), .out_data_o(e1_data), .out_sol_o(e1_sol)
    );

    stream_box_filter #(.DATA_W(8), .TAPS(3), .SHIFT(2), .EDGE_MODE(0)) u_s2 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(s2_ready),
        .in_data_i(in_data_i), .in_sol_i(in_sol_i),
        .out_valid_o(s2_valid), .out_ready_i(out_ready_i),
        .out_sum_o(s2_sum), .out_data_o(s2_data), .out_sol_o(s2_sol)
    );

    // Present one input beat, clock it, and settle 1 ns past the edge.
    task automatic beat(input logic v, input logic [7:0] d, input logic s);
        in_valid_i = v;
        in_data_i  = d;
        in_sol_i   = s;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'd0;
        in_sol_i    = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (e0_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", e0_valid); else n_pass++;
        n_checks++; if (e0_sum !== 10'd0) $display("FAIL reset_sum: got %0d expected 0", e0_sum); else n_pass++;
        n_checks++; if (e0_data !== 8'd0) $display("FAIL reset_data: got %0d expected 0", e0_data); else n_pass++;
        n_checks++; if (e0_sol !== 1'b0) $display("FAIL reset_sol: got %b expected 0", e0_sol); else n_pass++;
        n_checks++; if (e1_valid !== 1'b0 || s2_valid !== 1'b0) $display("FAIL reset_valid_all: got %b%b expected 00", e1_valid, s2_valid); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_checks++; if (e0_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", e0_ready); else n_pass++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_zero_edge();
        int px [4]  = '{1, 2, 3, 4};
        int exp [4] = '{1, 3, 6, 9};
        n_checks++; if (e0_valid !== 1'b0) $display("FAIL t1_idle_valid: got %b expected 0", e0_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 8'(px[i]), i == 0);
            n_checks++; if (e0_valid !== 1'b1) $display("FAIL t1_valid[%0d]: got %b expected 1", i, e0_valid); else n_pass++;
            n_checks++; if (e0_sum !== 10'(exp[i])) $display("FAIL t1_sum[%0d]: got %0d expected %0d", i, e0_sum, exp[i]); else n_pass++;
            n_checks++; if (e0_sol !== (i == 0)) $display("FAIL t1_sol[%0d]: got %b expected %b", i, e0_sol, i == 0); else n_pass++;
        end
        beat(1'b0, 8'd0, 1'b0);
        n_checks++; if (e0_valid !== 1'b0) $display("FAIL t1_drain_valid: got %b expected 0", e0_valid); else n_pass++;
    endtask

    task automatic test_replicate_edge();
        int px [6]     = '{1, 2, 3, 4, 10, 20};
        int sol [6]    = '{1, 0, 0, 0, 1, 0};
        int exp_e1 [6] = '{3, 4, 6, 9, 30, 40};
        int exp_e0 [6] = '{1, 3, 6, 9, 10, 30};
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 8'(px[i]), sol[i] != 0);
            n_checks++; if (e1_sum !== 10'(exp_e1[i])) $display("FAIL t2_rep_sum[%0d]: got %0d expected %0d", i, e1_sum, exp_e1[i]); else n_pass++;
            n_checks++; if (e0_sum !== 10'(exp_e0[i])) $display("FAIL t2_zero_sum[%0d]: got %0d expected %0d", i, e0_sum, exp_e0[i]); else n_pass++;
            n_checks++; if (e1_sol !== (sol[i] != 0)) $display("FAIL t2_sol[%0d]: got %b expected %b", i, e1_sol, sol[i] != 0); else n_pass++;
        end
        beat(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_normalise();
        int exp_sum [3]  = '{100, 200, 300};
        int exp_data [3] = '{25, 50, 75};
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 8'd100, i == 0);
            n_checks++; if (s2_sum !== 10'(exp_sum[i])) $display("FAIL t3_sum[%0d]: got %0d expected %0d", i, s2_sum, exp_sum[i]); else n_pass++;
            n_checks++; if (s2_data !== 8'(exp_data[i])) $display("FAIL t3_data[%0d]: got %0d expected %0d", i, s2_data, exp_data[i]); else n_pass++;
        end
        beat(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_saturation();
        int exp_sum [3] = '{255, 510, 765};
        int exp_s2 [3]  = '{63, 127, 191};
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 8'd255, i == 0);
            n_checks++; if (e0_sum !== 10'(exp_sum[i])) $display("FAIL t4_sum[%0d]: got %0d expected %0d", i, e0_sum, exp_sum[i]); else n_pass++;
            n_checks++; if (e0_data !== 8'd255) $display("FAIL t4_sat_data[%0d]: got %0d expected 255", i, e0_data); else n_pass++;
            n_checks++; if (s2_data !== 8'(exp_s2[i])) $display("FAIL t4_shift_data[%0d]: got %0d expected %0d", i, s2_data, exp_s2[i]); else n_pass++;
        end
        beat(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        int px [3]  = '{6, 7, 8};
        int exp [3] = '{11, 18, 21};
        out_ready_i = 1'b1;
        beat(1'b1, 8'd5, 1'b1);
        n_checks++; if (e0_sum !== 10'd5 || e0_valid !== 1'b1) $display("FAIL t5_first: got valid=%b sum=%0d expected valid=1 sum=5", e0_valid, e0_sum); else n_pass++;
        out_ready_i = 1'b0;
        in_data_i   = 8'd6;
        in_sol_i    = 1'b0;
        #1;
        n_checks++; if (e0_ready !== 1'b0) $display("FAIL t5_ready_comb: got %b expected 0", e0_ready); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i);
            #1;
            n_checks++; if (e0_ready !== 1'b0) $display("FAIL t5_stall_ready[%0d]: got %b expected 0", c, e0_ready); else n_pass++;
            n_checks++; if (e0_valid !== 1'b1 || e0_sum !== 10'd5) $display("FAIL t5_stall_hold[%0d]: got valid=%b sum=%0d expected valid=1 sum=5", c, e0_valid, e0_sum); else n_pass++;
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (e0_ready !== 1'b1) $display("FAIL t5_release_ready: got %b expected 1", e0_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 8'(px[i]), 1'b0);
            n_checks++; if (e0_sum !== 10'(exp[i])) $display("FAIL t5_sum[%0d]: got %0d expected %0d", i, e0_sum, exp[i]); else n_pass++;
        end
        beat(1'b0, 8'd0, 1'b0);
        n_checks++; if (e0_valid !== 1'b0) $display("FAIL t5_drain_valid: got %b expected 0", e0_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_row();
        beat(1'b1, 8'd1, 1'b1);
        beat(1'b1, 8'd2, 1'b0);
        beat(1'b1, 8'd3, 1'b0);
        n_checks++; if (e0_valid !== 1'b1 || e0_sum !== 10'd6) $display("FAIL t6_pre: got valid=%b sum=%0d expected valid=1 sum=6", e0_valid, e0_sum); else n_pass++;
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (e0_valid !== 1'b0 || e1_valid !== 1'b0) $display("FAIL t6_async_valid: got %b%b expected 00", e0_valid, e1_valid); else n_pass++;
        n_checks++; if (e0_sum !== 10'd0) $display("FAIL t6_async_sum: got %0d expected 0", e0_sum); else n_pass++;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        beat(1'b1, 8'd9, 1'b0);
        n_checks++; if (e0_sum !== 10'd9) $display("FAIL t6_zero_sum: got %0d expected 9", e0_sum); else n_pass++;
        n_checks++; if (e1_sum !== 10'd9) $display("FAIL t6_rep_sum: got %0d expected 9", e1_sum); else n_pass++;
        n_checks++; if (s2_data !== 8'd2) $display("FAIL t6_shift_data: got %0d expected 2", s2_data); else n_pass++;
        n_checks++; if (e0_sol !== 1'b0) $display("FAIL t6_sol: got %b expected 0", e0_sol); else n_pass++;
        beat(1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_edge();
        test_replicate_edge();
        test_normalise();
        test_saturation();
        test_backpressure();
        test_reset_mid_row();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
